rv32i_alu: RTL and testbench

RV32I integer ALU for the execute stage of the RISC-V core. It performs add, sub, shifts, signed and unsigned compares, and bitwise logic on two WIDTH-bit operands. It registers the result, so results appear one clock cycle after the operands are presented. It also provides a registered valid strobe and a zero flag for branch and forwarding logic.

---
 rtl/rv32i_alu.sv | 73 +++++++
 tb/tb_rv32i_alu.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - RV32I execute-stage ALU with registered result, valid strobe and zero flag
module rv32i_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] ALURes,
  output logic             valid_o,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);

  // ALUOp is {funct7[5], funct3}
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  // Only the low SHW bits of B select the shift distance; the rest are ignored
  logic [SHW-1:0]   sh;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] f;

  assign sh          = B[SHW-1:0];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;

  // Result selection; unassigned opcodes fall through to zero
  always_comb begin
    f = '0;
    case (ALUOp)
      OP_ADD:  f = A + B;
      OP_SUB:  f = A - B;
      OP_SLL:  f = A << sh;
      OP_SLT:  f = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: f = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_XOR:  f = A ^ B;
      OP_SRL:  f = A >> sh;
      OP_SRA:  f = $signed(A) >>> sh;
      OP_OR:   f = A | B;
      OP_AND:  f = A & B;
      default: f = '0;
    endcase
  end

  // Output registers: result and flag only load on valid_i, so idle inputs cannot disturb them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALURes  <= '0;
      valid_o <= 1'b0;
      Zero    <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        ALURes <= f;
        Zero   <= (f == '0);
      end
    end
  end

endmodule

// File: tb/tb_rv32i_alu.sv
// tb/tb_rv32i_alu.sv - table-driven self-checking bench for rv32i_alu
module tb_rv32i_alu;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALUOp;
  logic [31:0] ALURes;
  logic        valid_o;
  logic        Zero;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  rv32i_alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .A       (A),
    .B       (B),
    .ALUOp   (ALUOp),
    .ALURes  (ALURes),
    .valid_o (valid_o),
    .Zero    (Zero)
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop so the run cannot hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running req=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  function automatic void add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] res);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.res  = res;
    v.zero = (res == 32'h0);
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] held_res;
    logic        held_zero;

    total = 0;
    bad   = 0;

    // Arithmetic
    add_vec("add_10_5",      4'b0000, 32'd10,        32'd5,         32'd15);
    add_vec("sub_10_5",      4'b1000, 32'd10,        32'd5,         32'd5);
    add_vec("add_wrap",      4'b0000, 32'hFFFFFFFB,  32'd10,        32'd5);
    add_vec("sub_5_5",       4'b1000, 32'd5,         32'd5,         32'd0);
    add_vec("add_ovf",       4'b0000, 32'h7FFFFFFF,  32'd1,         32'h80000000);
    add_vec("sub_underflow", 4'b1000, 32'd0,         32'd1,         32'hFFFFFFFF);
    // Logic
    add_vec("and",           4'b0111, 32'hDEADBEEF,  32'h12345678,  32'h12241668);
    add_vec("xor",           4'b0100, 32'hDEADBEEF,  32'h12345678,  32'hCC99E897);
    add_vec("or",            4'b0110, 32'hDEADBEEF,  32'h12345678,  32'hDEBDFEFF);
    add_vec("op_1111",       4'b1111, 32'hDEADBEEF,  32'h12345678,  32'h0);
    add_vec("op_1001",       4'b1001, 32'hDEADBEEF,  32'h12345678,  32'h0);
    // Shifts
    add_vec("sll_10_2",      4'b0001, 32'd10,        32'd2,         32'd40);
    add_vec("sra_neg_2",     4'b1101, 32'hFFFFFFF8,  32'd2,         32'hFFFFFFFE);
    add_vec("srl_neg_2",     4'b0101, 32'hFFFFFFF8,  32'd2,         32'h3FFFFFFE);
    add_vec("sll_b_0x22",    4'b0001, 32'h12345678,  32'h22,        32'h48D159E0);
    add_vec("sra_min_31",    4'b1101, 32'h80000000,  32'd31,        32'hFFFFFFFF);
    add_vec("srl_min_31",    4'b0101, 32'h80000000,  32'd31,        32'h1);
    add_vec("sll_by_0",      4'b0001, 32'hDEADBEEF,  32'h0,         32'hDEADBEEF);
    add_vec("sra_by_0_b20",  4'b1101, 32'h80000001,  32'h20,        32'h80000001);
    // Compares
    add_vec("slt_neg_5",     4'b0010, 32'hFFFFFFFB,  32'd5,         32'd1);
    add_vec("sltu_neg_5",    4'b0011, 32'hFFFFFFFB,  32'd5,         32'd0);
    add_vec("slt_min_max",   4'b0010, 32'h80000000,  32'h7FFFFFFF,  32'd1);
    add_vec("sltu_min_max",  4'b0011, 32'h80000000,  32'h7FFFFFFF,  32'd0);
    add_vec("slt_equal",     4'b0010, 32'd7,         32'd7,         32'd0);
    add_vec("sltu_equal",    4'b0011, 32'd7,         32'd7,         32'd0);
    add_vec("xor_last",      4'b0100, 32'hA5A5A5A5,  32'h0F0F0F0F,  32'hAAAAAAAA);

    // Reset state while held in reset
    rst_n   = 1'b0;
    valid_i = 1'b0;
    A       = 32'h0;
    B       = 32'h0;
    ALUOp   = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_res",   ALURes,         32'h0);
    check("reset_valid", {31'b0, valid_o}, 32'h0);
    check("reset_zero",  {31'b0, Zero},    32'h0);

    // Release away from the edge, then run the table back to back
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid", {31'b0, valid_o}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      valid_i = 1'b1;
      A       = vecs[i].a;
      B       = vecs[i].b;
      ALUOp   = vecs[i].op;
      @(posedge clk);
      #1;
      check({vecs[i].name, "_res"},   ALURes,            vecs[i].res);
      check({vecs[i].name, "_zero"},  {31'b0, Zero},     {31'b0, vecs[i].zero});
      check({vecs[i].name, "_valid"}, {31'b0, valid_o},  32'h1);
    end

    // Idle for 3 cycles with noisy inputs: result and flag hold, valid drops
    held_res  = 32'hAAAAAAAA;
    held_zero = 1'b0;
    for (int c = 0; c < 3; c++) begin
      valid_i = 1'b0;
      A       = $urandom;
      B       = $urandom;
      ALUOp   = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check("hold_res",   ALURes,           held_res);
      check("hold_zero",  {31'b0, Zero},    {31'b0, held_zero});
      check("hold_valid", {31'b0, valid_o}, 32'h0);
    end

    // Burst interrupted by asynchronous reset mid-cycle
    valid_i = 1'b1;
    A       = 32'd100;
    B       = 32'd1;
    ALUOp   = 4'b0000;
    @(posedge clk);
    #1;
    check("burst1_res", ALURes, 32'd101);
    A = 32'd200;
    @(posedge clk);
    #1;
    check("burst2_res", ALURes, 32'd201);
    A = 32'd300;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_res",   ALURes,           32'h0);
    check("async_rst_valid", {31'b0, valid_o}, 32'h0);
    check("async_rst_zero",  {31'b0, Zero},    32'h0);
    @(posedge clk);
    #1;
    check("in_rst_valid", {31'b0, valid_o}, 32'h0);
    check("in_rst_res",   ALURes,           32'h0);

    // Release with valid_i low, then a fresh op must land exactly one cycle later
    valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle_valid", {31'b0, valid_o}, 32'h0);
    valid_i = 1'b1;
    A       = 32'd9;
    B       = 32'd4;
    ALUOp   = 4'b1000;
    @(negedge clk);
    check("post_rst_pre_edge_valid", {31'b0, valid_o}, 32'h0);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("post_rst_res",   ALURes,           32'd5);
    check("post_rst_valid", {31'b0, valid_o}, 32'h1);
    check("post_rst_zero",  {31'b0, Zero},    32'h0);
    @(posedge clk);
    #1;
    check("post_rst_drop_valid", {31'b0, valid_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
